// File: rtl/divider_8b_seq.sv
// Sequential unsigned restoring divider that drives an external subtractor_8b.
// It runs one quotient bit per RUN cycle and returns the result over valid/ready handshakes.
module divider_8b_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] sub_a_o,
  output logic [WIDTH-1:0] sub_b_o,
  input  logic [WIDTH-1:0] sub_diff_i,
  input  logic             sub_borrow_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH-1:0] shifted_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // The partial remainder stays below 2^step, so the shifted value always fits in WIDTH bits.
  always_comb begin
    shifted_r = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    r_d       = sub_borrow_i ? shifted_r : sub_diff_i;
    q_d       = {q_q[WIDTH-2:0], ~sub_borrow_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            q_q     <= dividend_i;
            d_q     <= divisor_i;
            r_q     <= '0;
            count_q <= '0;
            if (divisor_i == '0) begin
              state_q <= S_DONE;
              quot_q  <= '1;
              rem_q   <= dividend_i;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              dbz_q   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            state_q <= S_DONE;
            quot_q  <= q_d;
            rem_q   <= r_d;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o    = (state_q == S_IDLE);
  assign out_valid_o   = (state_q == S_DONE);
  assign sub_a_o       = shifted_r;
  assign sub_b_o       = d_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_8b_seq.sv
// Directed and randomised checks of divider_8b_seq, with the external subtractor modelled inline.
module tb_divider_8b_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic [7:0] sub_diff;
  logic       sub_borrow;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign sub_diff   = sub_a - sub_b;
  assign sub_borrow = (sub_a < sub_b);

  divider_8b_seq #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .sub_a_o      (sub_a),
    .sub_b_o      (sub_b),
    .sub_diff_i   (sub_diff),
    .sub_borrow_i (sub_borrow),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat counts clock edges after the accept edge until out_valid is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                       output int lat, output int acc_cyc);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {15'd0, in_ready}, 16'd1);
    tick();
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  logic [7:0] va [4] = '{8'd255, 8'd0, 8'd127, 8'd255};
  logic [7:0] vb [4] = '{8'd1,   8'd5, 8'd255, 8'd255};
  logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd0,   8'd1};
  logic [7:0] vr [4] = '{8'd0,   8'd0, 8'd127, 8'd0};

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int acc;
    int prev_acc;
    logic [7:0] a;
    logic [7:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready",  {15'd0, in_ready},    16'd1);
    chk("reset_out_valid", {15'd0, out_valid},   16'd0);
    chk("reset_quotient",  {8'd0, quotient},     16'd0);
    chk("reset_remainder", {8'd0, remainder},    16'd0);
    chk("reset_dbz",       {15'd0, div_by_zero}, 16'd0);

    // 200 / 7
    do_op(8'd200, 8'd7, 1'b0, lat, acc);
    chk("t1_latency",   16'(lat),             16'd8);
    chk("t1_quotient",  {8'd0, quotient},     16'd28);
    chk("t1_remainder", {8'd0, remainder},    16'd4);
    chk("t1_dbz",       {15'd0, div_by_zero}, 16'd0);
    tick();
    chk("t1_idle_ready", {15'd0, in_ready},  16'd1);
    chk("t1_idle_valid", {15'd0, out_valid}, 16'd0);

    // back-to-back with in_valid held high; accepts must be WIDTH+2 cycles apart
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b1, lat, acc);
      chk("t2_latency",   16'(lat),             16'd8);
      chk("t2_quotient",  {8'd0, quotient},     {8'd0, vq[i]});
      chk("t2_remainder", {8'd0, remainder},    {8'd0, vr[i]});
      chk("t2_dbz",       {15'd0, div_by_zero}, 16'd0);
      if (i > 0) chk("t2_throughput", 16'(acc - prev_acc), 16'd10);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    tick();

    // 13 / 0: result on the accept edge itself, no RUN cycles
    do_op(8'd13, 8'd0, 1'b0, lat, acc);
    chk("t3_latency",   16'(lat),             16'd0);
    chk("t3_quotient",  {8'd0, quotient},     16'h00FF);
    chk("t3_remainder", {8'd0, remainder},    16'd13);
    chk("t3_dbz",       {15'd0, div_by_zero}, 16'd1);
    chk("t3_in_ready",  {15'd0, in_ready},    16'd0);
    tick();
    chk("t3_idle_ready", {15'd0, in_ready}, 16'd1);

    // backpressure on 100 / 9
    out_ready = 1'b0;
    do_op(8'd100, 8'd9, 1'b0, lat, acc);
    chk("t4_latency", 16'(lat), 16'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid",     {15'd0, out_valid},   16'd1);
      chk("t4_hold_quotient",  {8'd0, quotient},     16'd11);
      chk("t4_hold_remainder", {8'd0, remainder},    16'd1);
      chk("t4_hold_dbz",       {15'd0, div_by_zero}, 16'd0);
      chk("t4_hold_in_ready",  {15'd0, in_ready},    16'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_idle_ready",     {15'd0, in_ready},  16'd1);
    chk("t4_idle_valid",     {15'd0, out_valid}, 16'd0);
    chk("t4_keep_quotient",  {8'd0, quotient},   16'd11);
    chk("t4_keep_remainder", {8'd0, remainder},  16'd1);

    // reset during step 4 of 50 / 3
    dividend = 8'd50;
    divisor  = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_running", {15'd0, in_ready}, 16'd0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_in_ready",  {15'd0, in_ready},    16'd1);
    chk("t5_out_valid", {15'd0, out_valid},   16'd0);
    chk("t5_quotient",  {8'd0, quotient},     16'd0);
    chk("t5_remainder", {8'd0, remainder},    16'd0);
    chk("t5_dbz",       {15'd0, div_by_zero}, 16'd0);
    tick();
    chk("t5_no_result", {15'd0, out_valid}, 16'd0);
    do_op(8'd50, 8'd3, 1'b0, lat, acc);
    chk("t5_latency",   16'(lat),          16'd8);
    chk("t5_quotient2", {8'd0, quotient},  16'd16);
    chk("t5_remainder2", {8'd0, remainder}, 16'd2);
    tick();

    // random operand pairs against the arithmetic reference
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_op(a, b, 1'b0, lat, acc);
      if (b == 8'd0) begin
        chk("rnd_latency",   16'(lat),             16'd0);
        chk("rnd_quotient",  {8'd0, quotient},     16'h00FF);
        chk("rnd_remainder", {8'd0, remainder},    {8'd0, a});
        chk("rnd_dbz",       {15'd0, div_by_zero}, 16'd1);
      end else begin
        chk("rnd_latency",   16'(lat),             16'd8);
        chk("rnd_quotient",  {8'd0, quotient},     {8'd0, a / b});
        chk("rnd_remainder", {8'd0, remainder},    {8'd0, a % b});
        chk("rnd_dbz",       {15'd0, div_by_zero}, 16'd0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
